// File: rtl/tone_gen.sv
// Square-wave tone generator: Hz request -> half-period via restoring divider,
// then a 50 % duty square wave on tone_out.
module tone_gen #(
    parameter int SYS_FREQ   = 100000000,
    parameter int FREQ_BITS  = 16,
    parameter int COUNT_BITS = $clog2(SYS_FREQ + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FREQ_BITS-1:0] freq_in,
    input  logic                 freq_valid,
    output logic                 freq_ready,
    input  logic                 enable,
    output logic                 tone_out,
    output logic                 busy
);

    localparam int STEP_BITS = $clog2(COUNT_BITS + 1);
    localparam int REM_W     = FREQ_BITS + 1;
    localparam logic [COUNT_BITS-1:0] DIVIDEND  = COUNT_BITS'(SYS_FREQ);
    localparam logic [STEP_BITS-1:0]  LAST_STEP = STEP_BITS'(COUNT_BITS);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        RUN
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic                   fromRun;
    logic [FREQ_BITS-1:0]   freqReg;
    logic [COUNT_BITS-1:0]  dvd;
    logic [COUNT_BITS-1:0]  quo;
    logic [REM_W-1:0]       rem;
    logic [STEP_BITS-1:0]   step;
    logic [COUNT_BITS-1:0]  half;
    logic [COUNT_BITS-1:0]  counter;
    logic                   tone;

    logic                   accept;
    logic                   acceptZero;
    logic                   lastStep;
    logic                   commit;
    logic                   active;
    logic [REM_W:0]         remShift;
    logic [REM_W:0]         divisor;
    logic                   geq;
    logic [REM_W-1:0]       remNext;
    logic [COUNT_BITS-1:0]  quoClamped;
    logic [COUNT_BITS-1:0]  halfLast;

    assign freq_ready = (state != DIVIDE);
    assign busy       = (state == DIVIDE);
    assign tone_out   = tone;

    assign accept     = freq_valid && freq_ready;
    assign acceptZero = accept && (freq_in == '0);
    assign lastStep   = (step == LAST_STEP);
    assign commit     = (state == DIVIDE) && lastStep;
    // The old tone keeps playing while a new period is being computed.
    assign active     = (state == RUN) || ((state == DIVIDE) && fromRun);

    assign remShift   = {rem, dvd[COUNT_BITS-1]};
    assign divisor    = {1'b0, freqReg, 1'b0};
    assign geq        = (remShift >= divisor);
    assign remNext    = geq ? REM_W'(remShift - divisor) : remShift[REM_W-1:0];
    assign quoClamped = (quo == '0) ? COUNT_BITS'(1) : quo;
    assign halfLast   = half - COUNT_BITS'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE, RUN: begin
                if (accept) begin
                    stateNext = (freq_in == '0) ? IDLE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (lastStep) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fromRun <= 1'b0;
            freqReg <= '0;
            dvd     <= '0;
            quo     <= '0;
            rem     <= '0;
            step    <= '0;
            half    <= '0;
        end else if (accept) begin
            fromRun <= (state == RUN);
            freqReg <= freq_in;
            dvd     <= DIVIDEND;
            quo     <= '0;
            rem     <= '0;
            step    <= '0;
            if (freq_in == '0) begin
                half <= '0;
            end
        end else if ((state == DIVIDE) && !lastStep) begin
            dvd  <= dvd << 1;
            quo  <= {quo[COUNT_BITS-2:0], geq};
            rem  <= remNext;
            step <= step + STEP_BITS'(1);
        end else if (commit) begin
            half <= quoClamped;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone    <= 1'b0;
            counter <= '0;
        end else if (acceptZero) begin
            tone    <= 1'b0;
            counter <= '0;
        end else if (commit) begin
            counter <= '0;
        end else if (!active || !enable) begin
            tone    <= 1'b0;
            counter <= '0;
        end else if (counter == halfLast) begin
            tone    <= ~tone;
            counter <= '0;
        end else begin
            counter <= counter + COUNT_BITS'(1);
        end
    end

endmodule
